// File: rtl/fractal_pkg.sv
// fractal_pkg
//   Types shared by the fractal AXI-Stream packer and its FIFO:
//   FSM state encoding, palette (color_mode) encodings, the pixel word that
//   travels through the FIFO, and the palette mapping function.
package fractal_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        DROP     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_GRAY   = 2'd0,   // R=G=B=data
        MODE_INV    = 2'd1,   // R=G=B=~data
        MODE_HEAT   = 2'd2,   // R=data, G=sat(2*data), B=255-data
        MODE_RGB332 = 2'd3    // data split 3:3:2, each field scaled to 8 bits
    } color_mode_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

    // Map an 8-bit iteration value to {R,G,B}.
    function automatic logic [23:0] palette(input color_mode_t mode, input logic [7:0] d);
        logic [7:0] r, g, b;
        case (mode)
            MODE_GRAY: begin
                r = d; g = d; b = d;
            end
            MODE_INV: begin
                r = ~d; g = ~d; b = ~d;
            end
            MODE_HEAT: begin
                r = d;
                g = d[7] ? 8'hFF : {d[6:0], 1'b0};   // 2*d saturated at 255
                b = 8'hFF - d;
            end
            default: begin
                // field*36 peaks at 252 and field*85 at 255, so 8 bits never overflow
                r = 8'({5'd0, d[7:5]} * 8'd36);
                g = 8'({5'd0, d[4:2]} * 8'd36);
                b = 8'({6'd0, d[1:0]} * 8'd85);
            end
        endcase
        return {r, g, b};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO. The head entry is visible on
//   rd_data whenever empty is low; rd_en pops it.
//   Ports:
//     clk, resetn        clock, async active-low reset (empties the FIFO)
//     wr_en, wr_data     push request / data (ignored while full)
//     full               no free entry (push+pop on a full FIFO still refuses the push)
//     rd_en              pop request (ignored while empty)
//     rd_data            head entry, forced to zero while empty
//     empty              no entry held
//   DEPTH must be a power of two, at least 4.
module sync_fifo_fwft #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Zero while empty so downstream sees clean data after reset. The head
    // slot is never overwritten while occupied, so it holds through stalls.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fractal_axis_packer.sv
// fractal_axis_packer
//   Converts the fractal generator's pixel beats into an AXI4-Stream video
//   stream: palette-maps each 8-bit iteration value to 24-bit RGB, tags the
//   first pixel of a frame (tuser) and the last of a line (tlast), and
//   buffers through a FWFT FIFO. After a FIFO overflow the rest of the frame
//   is discarded and capture resumes at the next frame_start.
//   Ports:
//     clk, resetn                     clock, async active-low reset
//     data, data_enable               pixel value / pixel valid
//     frame_start, line_end           frame and line markers
//     color_mode                      palette, taken on frame_start beats only
//     m_axis_tdata/tvalid/tready/
//     m_axis_tuser/tlast              AXI4-Stream master
//     overflow                        sticky, a beat was lost to a full FIFO
//     frame_count                     accepted frame starts, wrapping
module fractal_axis_packer
    import fractal_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  data,
    input  logic        data_enable,
    input  logic        frame_start,
    input  logic        line_end,
    input  logic [1:0]  color_mode,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [15:0] frame_count
);

    // ---------------- input register stage ----------------
    logic        in_de, in_fs, in_le;
    logic [7:0]  in_data;
    color_mode_t in_mode;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_de   <= 1'b0;
            in_fs   <= 1'b0;
            in_le   <= 1'b0;
            in_data <= '0;
            in_mode <= MODE_GRAY;
        end else begin
            in_de   <= data_enable;
            in_fs   <= frame_start;
            in_le   <= line_end;
            in_data <= data;
            in_mode <= color_mode_t'(color_mode);
        end
    end

    // ---------------- FSM ----------------
    state_t state_q, state_nx;
    logic   fifo_full, fifo_empty;
    logic   accept;      // registered beat belongs to a frame being captured
    logic   fifo_wr;
    logic   ovf_set;

    // A frame_start beat opens a frame from any state, so its own pixel
    // is captured even when the FSM is still in WAIT_SOF or DROP.
    assign accept = in_de && (in_fs || state_q == RUN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= WAIT_SOF;
        else         state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (in_fs)                 state_nx = RUN;
        if (accept && fifo_full)   state_nx = DROP;
    end

    always_comb begin
        fifo_wr = accept && !fifo_full;
        ovf_set = accept &&  fifo_full;
    end

    // ---------------- frame bookkeeping ----------------
    color_mode_t mode_q, mode_eff;
    logic        sof_pending;
    pixel_t      wr_pix, rd_pix;

    // The frame_start beat itself already uses the newly selected palette.
    assign mode_eff = in_fs ? in_mode : mode_q;

    always_comb begin
        wr_pix.rgb = palette(mode_eff, in_data);
        wr_pix.sof = in_fs | sof_pending;
        wr_pix.eol = in_le;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q      <= MODE_GRAY;
            sof_pending <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (in_fs) begin
                mode_q      <= in_mode;
                frame_count <= frame_count + 16'd1;
            end
            // The written pixel carries the start-of-frame flag away with it.
            if (fifo_wr)    sof_pending <= 1'b0;
            else if (in_fs) sof_pending <= 1'b1;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    // ---------------- output FIFO ----------------
    sync_fifo_fwft #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (fifo_wr),
        .wr_data (wr_pix),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (rd_pix),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = rd_pix.rgb;
    assign m_axis_tuser  = rd_pix.sof;
    assign m_axis_tlast  = rd_pix.eol;

endmodule

// File: tb/tb_fractal_axis_packer.sv
module tb_fractal_axis_packer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  data = '0;
    logic        data_enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_end = 1'b0;
    logic [1:0]  color_mode = '0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        overflow;
    logic [15:0] frame_count;

    int n_chk = 0;
    int n_err = 0;

    fractal_axis_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .data          (data),
        .data_enable   (data_enable),
        .frame_start   (frame_start),
        .line_end      (line_end),
        .color_mode    (color_mode),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Colour from the palette rules, using plain integer arithmetic.
    function automatic logic [23:0] color(input logic [1:0] m, input logic [7:0] d);
        int v, r, g, b;
        v = int'(d);
        case (m)
            2'd0: begin r = v; g = v; b = v; end
            2'd1: begin r = 255 - v; g = 255 - v; b = 255 - v; end
            2'd2: begin r = v; g = (2 * v > 255) ? 255 : 2 * v; b = 255 - v; end
            default: begin r = (v / 32) * 36; g = ((v / 4) % 8) * 36; b = (v % 4) * 85; end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Expected FIFO contents as {sof, eol, rgb}; a beat seen in cycle N is
    // resolved at the end of cycle N+1 (one input register stage).
    logic [25:0] mq[$];
    logic [25:0] acc_q[$];       // beats actually handed over on the stream
    bit          m_frame, m_drop, m_sof, m_ovf;
    logic [1:0]  m_mode;
    logic [15:0] m_fc;
    bit          p_de, p_fs, p_le;
    logic [7:0]  p_d;
    logic [1:0]  p_cm;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            mq.delete();
            m_frame = 0; m_drop = 0; m_sof = 0; m_ovf = 0;
            m_mode = '0; m_fc = '0;
            p_de = 0; p_fs = 0; p_le = 0; p_d = '0; p_cm = '0;
        end else begin
            bit was_full;
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && m_axis_tready) void'(mq.pop_front());
            if (p_fs) begin
                m_frame = 1; m_drop = 0; m_sof = 1; m_mode = p_cm; m_fc = m_fc + 16'd1;
            end
            if (p_de && m_frame && !m_drop) begin
                if (was_full) begin
                    m_ovf = 1; m_drop = 1;
                end else begin
                    mq.push_back({m_sof, p_le, color(m_mode, p_d)});
                    m_sof = 0;
                end
            end
            p_de = data_enable; p_fs = frame_start; p_le = line_end;
            p_d = data; p_cm = color_mode;
        end
    end

    // Compare process: outputs checked every out-of-reset cycle.
    initial forever begin
        @(negedge clk);
        if (resetn) begin
            chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
            if (mq.size() != 0)
                chk("stream", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(mq[0]));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_count", 32'(frame_count), 32'(m_fc));
            if (m_axis_tvalid && m_axis_tready)
                acc_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit de, input bit fs, input bit le, input logic [7:0] d,
                       input logic [1:0] cm, input bit rdy);
        data_enable = de; frame_start = fs; line_end = le; data = d;
        color_mode = cm; m_axis_tready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cyc(0, 0, 0, 8'h00, 2'd0, rdy);
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_q.size()) return 32'(acc_q[i]);
        return 'x;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_tvalid_async", 32'(m_axis_tvalid), 32'd0);
        idle(2, 1);
        resetn = 1'b1;
        idle(1, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        resetn = 1'b1;
        idle(2, 1);

        // 4x2 frame, mode 0, frame_start with first beat
        acc_q.delete();
        for (int i = 0; i < 8; i++)
            cyc(1, i == 0, (i == 3) || (i == 7), 8'(i), 2'd0, 1);
        idle(8, 1);
        chk("f4x2_count", 32'(acc_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [25:0] e;
            e = {i == 0, (i == 3) || (i == 7), 8'(i), 8'(i), 8'(i)};
            chk("f4x2_beat", acc_at(i), 32'(e));
        end
        chk("f4x2_frame_count", 32'(frame_count), 32'd1);

        // Palette spot values and mid-frame mode change
        acc_q.delete();
        cyc(1, 1, 0, 8'h90, 2'd2, 1);
        idle(4, 1);
        chk("mode2_0x90", acc_at(0), {6'd0, 2'b10, 24'h90FF6F});
        acc_q.delete();
        cyc(1, 1, 0, 8'hFF, 2'd3, 1);
        idle(4, 1);
        chk("mode3_0xFF", acc_at(0), {6'd0, 2'b10, 24'hFCFCFF});
        acc_q.delete();
        cyc(1, 1, 0, 8'h10, 2'd0, 1);
        cyc(1, 0, 1, 8'h10, 2'd3, 1);
        idle(4, 1);
        chk("mode_hold_a", acc_at(0), {6'd0, 2'b10, 24'h101010});
        chk("mode_hold_b", acc_at(1), {6'd0, 2'b01, 24'h101010});
        chk("mode1_model_pin", 32'(color(2'd1, 8'h0F)), 32'h00F0F0F0);

        // 384-pixel line, source every other cycle, tready toggling 1010...
        acc_q.delete();
        for (int i = 0; i < 384; i++) begin
            cyc(1, i == 0, i == 383, 8'(i), 2'd0, 1);
            cyc(0, 0, 0, 8'h00, 2'd0, 0);
        end
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 8'h00, 2'd0, i[0] == 1'b0);
        chk("line384_count", 32'(acc_q.size()), 32'd384);
        for (int i = 0; i < 384; i++)
            chk("line384_order", acc_at(i) & 32'hFF, 32'(i % 256));
        chk("line384_no_ovf", 32'(overflow), 32'd0);

        // Randomised frames
        for (int f = 0; f < 20; f++) begin
            int w;
            bit started;
            logic [1:0] cm;
            w = $urandom_range(4, 16);
            cm = 2'($urandom_range(0, 3));
            started = 0;
            if ($urandom_range(0, 1) == 1) begin
                cyc(0, 1, 0, 8'h00, cm, $urandom_range(0, 3) != 0);
                started = 1;
            end
            for (int l = 0; l < 3; l++) begin
                int k;
                k = 0;
                while (k < w) begin
                    if ($urandom_range(0, 9) < 7) begin
                        cyc(1, !started, k == w - 1, 8'($urandom), 2'($urandom),
                            $urandom_range(0, 3) != 0);
                        started = 1;
                        k++;
                    end else begin
                        cyc(0, 0, 0, 8'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
                    end
                end
            end
        end
        idle(DEPTH + 10, 1);

        // Overflow at exactly DEPTH+1 write attempts with tready low
        do_reset();
        acc_q.delete();
        for (int i = 0; i < DEPTH; i++) cyc(1, i == 0, 0, 8'(i), 2'd0, 0);
        idle(1, 0);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        cyc(1, 0, 0, 8'hEE, 2'd0, 0);
        idle(1, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        cyc(1, 0, 1, 8'hEF, 2'd0, 0);
        idle(DEPTH + 10, 1);
        chk("ovf_held_count", 32'(acc_q.size()), 32'(DEPTH));
        chk("ovf_last_held", acc_at(DEPTH - 1), {6'd0, 2'b00, {3{8'(DEPTH - 1)}}});
        acc_q.delete();
        cyc(1, 1, 0, 8'hA5, 2'd0, 1);
        cyc(1, 0, 1, 8'h5A, 2'd0, 1);
        idle(4, 1);
        chk("ovf_next_frame_a", acc_at(0), {6'd0, 2'b10, 24'hA5A5A5});
        chk("ovf_next_frame_b", acc_at(1), {6'd0, 2'b01, 24'h5A5A5A});
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-line with the FIFO half full, then beats before frame_start
        for (int i = 0; i < DEPTH / 2; i++) cyc(1, i == 0, 0, 8'(i), 2'd0, 0);
        chk("half_full_valid", 32'(m_axis_tvalid), 32'd1);
        do_reset();
        chk("post_rst_ovf", 32'(overflow), 32'd0);
        chk("post_rst_fc", 32'(frame_count), 32'd0);
        acc_q.delete();
        for (int i = 0; i < 12; i++) cyc(1, 0, i == 11, 8'(i + 1), 2'd0, 1);
        idle(6, 1);
        chk("pre_sof_no_output", 32'(acc_q.size()), 32'd0);
        chk("pre_sof_fc", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
